pc_fetch: RTL
=============

# pc_fetch

Program-counter register and instruction-fetch sequencer, sitting directly downstream of the next-PC mux. It holds the architectural fetch PC, feeds `pc4` back to the mux and loads the mux's `real_npc` output. It runs a single-outstanding request/grant/response handshake to instruction memory and presents each fetched word to decode through a one-entry valid/ready buffer. Redirects (branch/exception) flush in-flight fetches.

## Interface
- `RESET_PC`, 32'h0000_3000, PC value loaded on reset.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `real_npc`  in  32  next PC from the next-PC mux.
- `flush`  in  1  redirect; asserted in the same cycle the mux selects `epc`/`npc`.
- `stall`  in  1  hazard hold; blocks new fetch issue.
- `pc`  out  32  current fetch PC register.
- `pc4`  out  32  `pc + 4`, combinational, to the next-PC mux.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  request address.
- `imem_gnt`  in  1  request accepted.
- `imem_rvalid`  in  1  response valid.
- `imem_rdata`  in  32  response word.
- `if_valid`  out  1  decode buffer holds an instruction.
- `if_pc`  out  32  PC of the buffered instruction.
- `if_instr`  out  32  buffered instruction.
- `if_addr_err`  out  1  buffered entry is a misaligned-fetch marker.
- `id_ready`  in  1  decode consumes the buffer entry when `if_valid & id_ready`.

## Operation
- States: IDLE, REQ, WAIT.
- IDLE:
  - Issue when `!stall && !flush` and the buffer is free (empty, or consumed this cycle).
  - Issue does `req_addr <= pc`, `pc <= real_npc` (equals `pc4` when no redirect), and moves to REQ.
- REQ:
  - `imem_req = 1` and `imem_addr = req_addr`.
  - Address and request stay stable until `imem_gnt`; the request is never withdrawn.
  - On `imem_gnt`, move to WAIT.
- WAIT:
  - On `imem_rvalid`, if `kill` is clear: `if_valid <= 1`, `if_pc <= req_addr`, `if_instr <= imem_rdata`.
  - In either case, clear `kill` and move to IDLE.
- `flush` (any state):
  - `pc <= real_npc`.
  - Buffer cleared (`if_valid <= 0`).
  - If in REQ, or in WAIT without `rvalid` this cycle, set `kill` so the outstanding response is dropped.
  - `rvalid` arriving in the same cycle as `flush` is dropped.
  - Flush has priority over issue and over `stall`.
- `stall` affects only issue. An outstanding fetch still completes into the buffer.
- `imem_rvalid`/`imem_gnt` outside WAIT/REQ respectively are ignored.
- Arithmetic: `pc4 = pc + 32'd4`, modulo 2^32; 32'hFFFF_FFFC wraps to 0.

## Timing
- Reset values:
  - `pc = RESET_PC`; state IDLE; `kill = 0`.
  - `imem_req = 0`; `imem_addr = RESET_PC`.
  - `if_valid = 0`; `if_pc = 0`; `if_instr = 0`; `if_addr_err = 0`.
- Reset mid-operation: state returns to IDLE, and any pending memory response is ignored.
- Minimum latency with same-cycle grant and next-cycle response:
  - Issue in cycle t, `imem_req` in t+1 (granted), `rvalid` in t+2, `if_valid` in t+3.
  - One instruction per 3 cycles.
- Each extra grant-wait or response-wait cycle adds one cycle.
- `pc` updates on the issue edge or the flush edge only.

## Configuration
- `FETCH_ADDR_CHECK_EN` defined:
  - At issue, if `pc[1:0] != 0`, no memory request is made.
  - The buffer is loaded next cycle with `if_addr_err = 1`, `if_instr = 32'h0` (NOP), `if_pc = pc`.
  - `pc` still loads `real_npc`.
- Not defined: `if_addr_err` is tied to 0, `imem_addr` is forced word-aligned (`{pc[31:2],2'b00}`), and no check is made.

## Structure
- Shared package `mips_pkg`:
  - `fetch_state_t` enum (IDLE/REQ/WAIT).
  - `NOP_INSTR` constant 32'h0.
  - `RESET_PC_DEFAULT` constant.
- Sub-module `fetch_buf`: one-entry valid/ready output register with load, consume and clear ports. The FSM and PC register stay in `pc_fetch`.

## Test plan
- Reset, then zero-wait memory returning `imem_rdata = addr ^ 32'hA5A5_0000`, `id_ready = 1`, 4 instructions -> `if_pc` 0x3000, 0x3004, 0x3008, 0x300C each with matching data, one per 3 cycles.
- `id_ready = 0` after the first fetch -> `if_valid` held with `if_pc = 0x3000`, no new `imem_req` until `id_ready` rises.
- `flush` with `real_npc = 0x4000` during WAIT -> the response for the old address is dropped (`if_valid` stays 0), and the next request has `imem_addr = 0x4000`.
- `stall = 1` in IDLE for 5 cycles -> `imem_req = 0` and `pc` unchanged; after release, the fetch issues at the held PC.
- Grant delayed 3 cycles -> `imem_req`/`imem_addr` stable throughout; `flush` in the same cycle as a rising `rvalid` -> the word is discarded.
- With `FETCH_ADDR_CHECK_EN`, `flush` to `real_npc = 0x4002` -> no memory request; `if_valid = 1`, `if_addr_err = 1`, `if_instr = 0`, `if_pc = 0x4002`.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared fetch-stage types and constants for the pc_fetch slice.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

endpackage

// File: rtl/fetch_buf.sv
// One-entry valid/ready buffer between fetch and decode.
// Clear beats load, load beats consume.
module fetch_buf
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] ld_pc,
  input  logic [31:0] ld_instr,
  input  logic        ld_err,
  input  logic        consume,
  input  logic        clear,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        addr_err
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= 1'b0;
      pc       <= 32'h0;
      instr    <= NOP_INSTR;
      addr_err <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid    <= 1'b1;
      pc       <= ld_pc;
      instr    <= ld_instr;
      addr_err <= ld_err;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// PC register and single-outstanding instruction-fetch sequencer.
// Optional misaligned-fetch check enabled by defining FETCH_ADDR_CHECK_EN.
module pc_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] real_npc,
  input  logic        flush,
  input  logic        stall,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_addr_err,
  input  logic        id_ready
);

  fetch_state_t state;
  logic [31:0]  req_addr;
  logic         kill;
  logic         misalign;
  logic         buf_free;
  logic         issue;
  logic         buf_load;
  logic         ld_err;
  logic [31:0]  ld_pc;
  logic [31:0]  ld_instr;

  assign pc4 = pc + 32'd4;

`ifdef FETCH_ADDR_CHECK_EN
  assign misalign  = (pc[1:0] != 2'b00);
  assign imem_addr = req_addr;
`else
  assign misalign  = 1'b0;
  assign imem_addr = {req_addr[31:2], 2'b00};
`endif

  // A misaligned issue skips memory and drops an error marker straight into the buffer.
  always_comb begin
    buf_free = !if_valid || id_ready;
    issue    = (state == IDLE) && !stall && !flush && buf_free;
    buf_load = 1'b0;
    ld_pc    = req_addr;
    ld_instr = imem_rdata;
    ld_err   = 1'b0;
    if (issue && misalign) begin
      buf_load = 1'b1;
      ld_pc    = pc;
      ld_instr = NOP_INSTR;
      ld_err   = 1'b1;
    end else if ((state == WAIT) && imem_rvalid && !kill && !flush) begin
      buf_load = 1'b1;
    end
  end

  // A flushed fetch still runs its handshake to completion; kill discards its word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      kill     <= 1'b0;
      imem_req <= 1'b0;
    end else if (flush) begin
      pc <= real_npc;
      case (state)
        REQ: begin
          kill <= 1'b1;
          if (imem_gnt) begin
            state    <= WAIT;
            imem_req <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            kill  <= 1'b0;
            state <= IDLE;
          end else begin
            kill <= 1'b1;
          end
        end
        default: ;
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            req_addr <= pc;
            pc       <= real_npc;
            if (!misalign) begin
              state    <= REQ;
              imem_req <= 1'b1;
            end
          end
        end
        REQ: begin
          if (imem_gnt) begin
            state    <= WAIT;
            imem_req <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            kill  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  fetch_buf u_buf (
    .clk      (clk),
    .rst      (rst),
    .load     (buf_load),
    .ld_pc    (ld_pc),
    .ld_instr (ld_instr),
    .ld_err   (ld_err),
    .consume  (if_valid && id_ready),
    .clear    (flush),
    .valid    (if_valid),
    .pc       (if_pc),
    .instr    (if_instr),
    .addr_err (if_addr_err)
  );

endmodule
